alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_seq.sv | 110 +++++++++++
 tb/tb_alu_seq.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states and data width.
package alu_pkg;

  localparam int DW = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_ROL = 3'b110;
  localparam logic [2:0] OP_ROR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Only add/sub produce a carry worth keeping for multi-nibble chains.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_seq.sv
// Command sequencer and accumulator feeding an external 4-bit ALU; registers the
// ALU inputs, captures the result after a settle interval and hands it downstream.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [DW-1:0] cmd_a,
  input  logic [DW-1:0] cmd_b,
  input  logic          cmd_cin,
  input  logic          cmd_use_acc,
  input  logic          cmd_chain,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic          alu_cin,
  output logic [2:0]    alu_ctrl,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_cout,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_cout
);

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          carry_q, carry_d;
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic          alu_cin_q, alu_cin_d;
  logic [2:0]    alu_ctrl_q, alu_ctrl_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_cin_d  = alu_cin_q;
    alu_ctrl_d = alu_ctrl_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          alu_ctrl_d = cmd_op;
          alu_a_d    = cmd_use_acc ? acc_q : cmd_a;
          alu_b_d    = cmd_b;
          alu_cin_d  = cmd_chain ? carry_q : cmd_cin;
          cnt_d      = CNT_LOAD;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          acc_d   = alu_out;
          // Logic and shift ops leave the carry flag for a later chained add/sub.
          if (is_arith(alu_ctrl_q)) carry_d = alu_cout;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_cin_q  <= 1'b0;
      alu_ctrl_q <= OP_ADD;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_cin_q  <= alu_cin_d;
      alu_ctrl_q <= alu_ctrl_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign res_valid = (state_q == HOLD);
  assign res_data  = acc_q;
  assign res_cout  = carry_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_cin   = alu_cin_q;
  assign alu_ctrl  = alu_ctrl_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: two instances (1 and 3 settle cycles) each driving a behavioural ALU.
module tb_alu_seq;

  logic clk;
  logic rst_n;

  // Reference ALU: sub reports borrow in cout; logic/shift ops report the bit shifted out or 0.
  function automatic logic [4:0] alu_model(input logic [2:0] op, input logic [3:0] a,
                                           input logic [3:0] b, input logic cin);
    logic [4:0] r;
    case (op)
      3'b000: r = {1'b0, a} + {1'b0, b} + {4'b0, cin};
      3'b001: r = {1'b0, a} - {1'b0, b} - {4'b0, cin};
      3'b010: r = {1'b0, a | b};
      3'b011: r = {1'b0, a & b};
      3'b100: r = {a[3], a[2:0], 1'b0};
      3'b101: r = {a[0], 1'b0, a[3:1]};
      3'b110: r = {a[3], a[2:0], a[3]};
      default: r = {a[0], a[0], a[3:1]};
    endcase
    return r;
  endfunction

  // Instance 1: EXEC_CYCLES = 1
  logic       cmd_valid1, cmd_ready1, cmd_cin1, cmd_use_acc1, cmd_chain1;
  logic [2:0] cmd_op1, alu_ctrl1;
  logic [3:0] cmd_a1, cmd_b1, alu_a1, alu_b1, alu_out1, res_data1;
  logic       alu_cin1, alu_cout1, res_valid1, res_ready1, res_cout1;

  // Instance 3: EXEC_CYCLES = 3
  logic       cmd_valid3, cmd_ready3, cmd_cin3, cmd_use_acc3, cmd_chain3;
  logic [2:0] cmd_op3, alu_ctrl3;
  logic [3:0] cmd_a3, cmd_b3, alu_a3, alu_b3, alu_out3, res_data3;
  logic       alu_cin3, alu_cout3, res_valid3, res_ready3, res_cout3;

  always_comb {alu_cout1, alu_out1} = alu_model(alu_ctrl1, alu_a1, alu_b1, alu_cin1);
  always_comb {alu_cout3, alu_out3} = alu_model(alu_ctrl3, alu_a3, alu_b3, alu_cin3);

  alu_seq #(.EXEC_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_op(cmd_op1),
    .cmd_a(cmd_a1), .cmd_b(cmd_b1), .cmd_cin(cmd_cin1),
    .cmd_use_acc(cmd_use_acc1), .cmd_chain(cmd_chain1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_cin(alu_cin1), .alu_ctrl(alu_ctrl1),
    .alu_out(alu_out1), .alu_cout(alu_cout1),
    .res_valid(res_valid1), .res_ready(res_ready1),
    .res_data(res_data1), .res_cout(res_cout1)
  );

  alu_seq #(.EXEC_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_op(cmd_op3),
    .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_cin(cmd_cin3),
    .cmd_use_acc(cmd_use_acc3), .cmd_chain(cmd_chain3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_cin(alu_cin3), .alu_ctrl(alu_ctrl3),
    .alu_out(alu_out3), .alu_cout(alu_cout3),
    .res_valid(res_valid3), .res_ready(res_ready3),
    .res_data(res_data3), .res_cout(res_cout3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       use_acc;
    logic       chain;
    logic [3:0] exp_alu_a;
    logic       exp_alu_cin;
    logic [3:0] exp_data;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[11];

  // One full transaction on instance 1: accept, measure latency, check, then drain.
  task automatic run1(input int idx, input vec_t v);
    int lat;
    cmd_op1 = v.op; cmd_a1 = v.a; cmd_b1 = v.b; cmd_cin1 = v.cin;
    cmd_use_acc1 = v.use_acc; cmd_chain1 = v.chain; cmd_valid1 = 1'b1;
    res_ready1 = 1'b0;
    lat = 0;
    while (!cmd_ready1 && lat < 20) begin @(posedge clk); #1; lat++; end
    check($sformatf("v%0d_ready", idx), {7'd0, cmd_ready1}, 8'd1);
    @(posedge clk); #1;
    cmd_valid1 = 1'b0;
    check($sformatf("v%0d_alu_a", idx), {4'd0, alu_a1}, {4'd0, v.exp_alu_a});
    check($sformatf("v%0d_alu_cin", idx), {7'd0, alu_cin1}, {7'd0, v.exp_alu_cin});
    check($sformatf("v%0d_alu_ctrl", idx), {5'd0, alu_ctrl1}, {5'd0, v.op});
    lat = 0;
    while (!res_valid1 && lat < 20) begin @(posedge clk); #1; lat++; end
    check($sformatf("v%0d_latency", idx), 8'(lat), 8'd1);
    check($sformatf("v%0d_data", idx), {4'd0, res_data1}, {4'd0, v.exp_data});
    check($sformatf("v%0d_cout", idx), {7'd0, res_cout1}, {7'd0, v.exp_cout});
    res_ready1 = 1'b1;
    @(posedge clk); #1;
    res_ready1 = 1'b0;
    check($sformatf("v%0d_idle", idx), {6'd0, res_valid1, cmd_ready1}, 8'd1);
    $display("vec %0d op=%0d a=%0h b=%0h -> data=%0h cout=%0b", idx, v.op, v.a, v.b,
             res_data1, res_cout1);
  endtask

  initial begin
    int lat;
    logic seen;

    //           op     a      b      cin   acc   chain  ea     ecin  data   cout
    vecs[0]  = '{3'd0, 4'h5, 4'h3, 1'b0, 1'b0, 1'b0, 4'h5, 1'b0, 4'h8, 1'b0};
    vecs[1]  = '{3'd3, 4'h0, 4'hC, 1'b0, 1'b1, 1'b0, 4'h8, 1'b0, 4'h8, 1'b0};
    vecs[2]  = '{3'd0, 4'hF, 4'h1, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 4'h0, 1'b1};
    vecs[3]  = '{3'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 4'h1, 1'b0};
    vecs[4]  = '{3'd1, 4'h3, 4'h5, 1'b0, 1'b0, 1'b0, 4'h3, 1'b0, 4'hE, 1'b1};
    vecs[5]  = '{3'd2, 4'h5, 4'hA, 1'b0, 1'b0, 1'b0, 4'h5, 1'b0, 4'hF, 1'b1};
    vecs[6]  = '{3'd4, 4'h9, 4'h0, 1'b0, 1'b0, 1'b0, 4'h9, 1'b0, 4'h2, 1'b1};
    vecs[7]  = '{3'd5, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h2, 1'b0, 4'h1, 1'b1};
    vecs[8]  = '{3'd7, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 4'h8, 1'b1};
    vecs[9]  = '{3'd1, 4'h8, 4'h3, 1'b0, 1'b0, 1'b1, 4'h8, 1'b1, 4'h4, 1'b0};
    vecs[10] = '{3'd0, 4'h7, 4'h8, 1'b1, 1'b0, 1'b0, 4'h7, 1'b1, 4'h0, 1'b1};

    cmd_valid1 = 0; cmd_op1 = 0; cmd_a1 = 0; cmd_b1 = 0; cmd_cin1 = 0;
    cmd_use_acc1 = 0; cmd_chain1 = 0; res_ready1 = 0;
    cmd_valid3 = 0; cmd_op3 = 0; cmd_a3 = 0; cmd_b3 = 0; cmd_cin3 = 0;
    cmd_use_acc3 = 0; cmd_chain3 = 0; res_ready3 = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", {7'd0, cmd_ready1}, 8'd1);
    check("rst_res_valid", {7'd0, res_valid1}, 8'd0);
    check("rst_alu_regs", {alu_a1, alu_b1}, 8'h00);
    check("rst_ctrl_cin", {4'd0, alu_ctrl1, alu_cin1}, 8'd0);
    check("rst_result", {3'd0, res_cout1, res_data1}, 8'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset released");

    for (int i = 0; i < 11; i++) run1(i, vecs[i]);

    // Backpressure: result held while the next command waits at the input.
    cmd_op1 = 3'd0; cmd_a1 = 4'h2; cmd_b1 = 4'h2; cmd_cin1 = 0;
    cmd_use_acc1 = 0; cmd_chain1 = 0; cmd_valid1 = 1'b1;
    @(posedge clk); #1;
    cmd_op1 = 3'd2; cmd_a1 = 4'h1; cmd_b1 = 4'h0;
    lat = 0;
    while (!res_valid1 && lat < 20) begin @(posedge clk); #1; lat++; end
    check("bp_first_latency", 8'(lat), 8'd1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold%0d", i), {2'd0, res_valid1, cmd_ready1, res_data1}, 8'h24);
      @(posedge clk); #1;
    end
    res_ready1 = 1'b1;
    @(posedge clk); #1;
    res_ready1 = 1'b0;
    check("bp_release_ready", {7'd0, cmd_ready1}, 8'd1);
    @(posedge clk); #1;
    cmd_valid1 = 1'b0;
    check("bp_second_accept", {3'd0, cmd_ready1, alu_a1}, 8'h01);
    lat = 0;
    while (!res_valid1 && lat < 20) begin @(posedge clk); #1; lat++; end
    check("bp_second_data", {4'd0, res_data1}, 8'h01);
    res_ready1 = 1'b1;
    @(posedge clk); #1;
    res_ready1 = 1'b0;
    $display("backpressure sequence done data=%0h", res_data1);

    // Settle interval of 3 cycles on the second instance: rol 1001 -> 0011.
    cmd_op3 = 3'd6; cmd_a3 = 4'b1001; cmd_b3 = 4'h0; cmd_valid3 = 1'b1;
    @(posedge clk); #1;
    cmd_valid3 = 1'b0;
    lat = 0;
    while (!res_valid3 && lat < 20) begin @(posedge clk); #1; lat++; end
    check("settle_latency", 8'(lat), 8'd3);
    check("settle_data", {4'd0, res_data3}, 8'h03);
    res_ready3 = 1'b1;
    @(posedge clk); #1;
    res_ready3 = 1'b0;
    $display("settle rol lat=%0d data=%0h", lat, res_data3);

    // Reset asserted mid-EXEC; outputs must clear without waiting for a clock.
    cmd_op3 = 3'd0; cmd_a3 = 4'h5; cmd_b3 = 4'h5; cmd_valid3 = 1'b1;
    @(posedge clk); #1;
    cmd_valid3 = 1'b0;
    @(posedge clk); #1;
    check("mid_exec_busy", {7'd0, cmd_ready3}, 8'd0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_alu_regs", {alu_a3, alu_b3}, 8'h00);
    check("arst_ctrl_cin", {4'd0, alu_ctrl3, alu_cin3}, 8'd0);
    check("arst_result", {3'd0, res_cout3, res_data3}, 8'd0);
    check("arst_handshake", {6'd0, res_valid3, cmd_ready3}, 8'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (res_valid3) seen = 1'b1;
    end
    check("post_rst_no_valid", {7'd0, seen}, 8'd0);
    cmd_op3 = 3'd0; cmd_a3 = 4'h1; cmd_b3 = 4'h1; cmd_valid3 = 1'b1;
    @(posedge clk); #1;
    cmd_valid3 = 1'b0;
    lat = 0;
    while (!res_valid3 && lat < 20) begin @(posedge clk); #1; lat++; end
    check("post_rst_cmd", {3'd0, res_cout3, res_data3}, 8'h02);
    res_ready3 = 1'b1;
    @(posedge clk); #1;
    res_ready3 = 1'b0;
    $display("reset-mid-exec sequence done data=%0h", res_data3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
